// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter: shares one fifo_sync write port between NREQ
// producers, granting bursts of up to BURST words with a one-cycle bubble between grants.
module fifo_wr_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DSIZE = 8,
  parameter int unsigned BURST = 4,
  localparam int unsigned IW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       req_ack,
  output logic [NREQ-1:0]       gnt,
  output logic [IW-1:0]         gnt_id,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata
);

  localparam int unsigned BW = $clog2(BURST) + 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   gnt_id_q, gnt_id_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [IW-1:0]   last_q, last_d;

  logic             pick_found;
  logic [IW-1:0]    pick_id;
  logic [IW-1:0]    scan_idx;
  logic             owner_req;
  logic [DSIZE-1:0] owner_data;
  logic             burst_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      beat_q   <= '0;
      last_q   <= IW'(NREQ - 1);
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      beat_q   <= beat_d;
      last_q   <= last_d;
    end
  end

  // Rotating priority scan starting just after the previous owner.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    scan_idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      scan_idx = IW'((32'(last_q) + k) % NREQ);
      if (!pick_found && req[scan_idx]) begin
        pick_found = 1'b1;
        pick_id    = scan_idx;
      end
    end
  end

  always_comb begin
    owner_req  = 1'b0;
    owner_data = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (gnt_id_q == IW'(i)) begin
        owner_req  = req[i];
        owner_data = req_data[i*DSIZE +: DSIZE];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    beat_d    = beat_q;
    last_d    = last_q;
    winc      = 1'b0;
    wdata     = '0;
    req_ack   = '0;
    burst_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d  = GRANT;
          gnt_d    = NREQ'(1) << pick_id;
          gnt_id_d = pick_id;
          beat_d   = '0;
        end
      end
      default: begin
        wdata = owner_data;
        winc  = owner_req & ~wfull;
        if (winc) begin
          req_ack = NREQ'(1) << gnt_id_q;
          if (beat_q == BW'(BURST - 1)) begin
            burst_end = 1'b1;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end else if (!owner_req) begin
          burst_end = 1'b1;
        end
        // wfull with the owner still requesting falls through: grant and count hold.
        if (burst_end) begin
          state_d  = IDLE;
          last_d   = gnt_id_q;
          gnt_d    = '0;
          gnt_id_d = '0;
          beat_d   = '0;
        end
      end
    endcase
  end

  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;

endmodule
